// File: rtl/cla_pkg.sv
// Shared op encoding and the generate/propagate combine used by the lookahead tree.
package cla_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Combine a high (g,p) group with the adjacent low group; returns {g, p}.
   function automatic logic [1:0] gp_merge(input logic g_hi, input logic p_hi,
                                           input logic g_lo, input logic p_lo);
      return {g_hi | (p_hi & g_lo), p_hi & p_lo};
   endfunction

endpackage

// File: rtl/cla_pipe_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface cla_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_op;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_b, in_op, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/cla_block.sv
// One combinational BLOCK-bit lookahead slice: 4-bit groups resolved locally,
// group carries resolved by a second lookahead level driven straight from cin.
module cla_block
   import cla_pkg::*;
#(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             g,
   output logic             p,
   output logic             cout,
   output logic             c_msb_in
);
   localparam int NG = BLOCK / 4;

   logic [BLOCK-1:0] bg, bp;
   logic [BLOCK-1:0] pg, pp;
   logic [NG-1:0]    gg, gpp;
   logic [NG-1:0]    ag, ap;
   logic [NG-1:0]    gc;
   logic [BLOCK-1:0] c;

   always_comb begin
      bg  = a & b;
      bp  = a ^ b;
      pg  = '0;
      pp  = '0;
      gg  = '0;
      gpp = '0;
      ag  = '0;
      ap  = '0;
      gc  = '0;
      c   = '0;

      // pg/pp[i]: prefix from the start of the bit's 4-bit group up to bit i
      for (int i = 0; i < BLOCK; i++) begin
         if (i % 4 == 0)
            {pg[i], pp[i]} = {bg[i], bp[i]};
         else
            {pg[i], pp[i]} = gp_merge(bg[i], bp[i], pg[i-1], pp[i-1]);
      end
      for (int j = 0; j < NG; j++) begin
         gg[j]  = pg[4*j+3];
         gpp[j] = pp[4*j+3];
      end

      {ag[0], ap[0]} = {gg[0], gpp[0]};
      for (int j = 1; j < NG; j++)
         {ag[j], ap[j]} = gp_merge(gg[j], gpp[j], ag[j-1], ap[j-1]);

      gc[0] = cin;
      for (int j = 1; j < NG; j++)
         gc[j] = ag[j-1] | (ap[j-1] & cin);

      for (int i = 0; i < BLOCK; i++) begin
         if (i % 4 == 0)
            c[i] = gc[i/4];
         else
            c[i] = pg[i-1] | (pp[i-1] & gc[i/4]);
      end
   end

   assign sum      = bp ^ c;
   assign g        = ag[NG-1];
   assign p        = ap[NG-1];
   assign cout     = ag[NG-1] | (ap[NG-1] & cin);
   assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit slice per stage,
// carry registered between stages, whole pipe freezes on output backpressure.
module cla_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input logic       clk,
   input logic       rst_n,
   cla_pipe_if.slave bus
);
   localparam int NSTAGE = WIDTH / BLOCK;

   typedef logic [WIDTH-1:0] word_t;

   word_t            a_src   [NSTAGE];
   word_t            b_src   [NSTAGE];
   word_t            sum_src [NSTAGE];
   word_t            sum_nxt [NSTAGE];
   logic             cin_src [NSTAGE];
   logic             carry_nxt [NSTAGE];

   logic [BLOCK-1:0] blk_sum  [NSTAGE];
   logic             blk_g    [NSTAGE];
   logic             blk_p    [NSTAGE];
   logic             blk_cout [NSTAGE];
   logic             blk_cmsb [NSTAGE];

   word_t            a_reg     [NSTAGE];
   word_t            b_reg     [NSTAGE];
   word_t            sum_reg   [NSTAGE];
   logic             carry_reg [NSTAGE];
   logic             valid_reg [NSTAGE];
   logic             ovf_reg;
   logic             zero_reg;

   logic             stall;

   assign stall = valid_reg[NSTAGE-1] & ~bus.out_ready;

   // Subtract is A + ~B + 1, formed once at the pipe entry.
   assign a_src[0]   = bus.in_a;
   assign b_src[0]   = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
   assign cin_src[0] = (bus.in_op == OP_SUB) ? 1'b1 : bus.in_cin;
   assign sum_src[0] = '0;

   generate
      for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
         if (gi > 0) begin : g_feed
            assign a_src[gi]   = a_reg[gi-1];
            assign b_src[gi]   = b_reg[gi-1];
            assign cin_src[gi] = carry_reg[gi-1];
            assign sum_src[gi] = sum_reg[gi-1];
         end

         cla_block #(
            .BLOCK (BLOCK)
         ) u_blk (
            .a        (a_src[gi][gi*BLOCK +: BLOCK]),
            .b        (b_src[gi][gi*BLOCK +: BLOCK]),
            .cin      (cin_src[gi]),
            .sum      (blk_sum[gi]),
            .g        (blk_g[gi]),
            .p        (blk_p[gi]),
            .cout     (blk_cout[gi]),
            .c_msb_in (blk_cmsb[gi])
         );

         assign carry_nxt[gi] = blk_g[gi] | (blk_p[gi] & cin_src[gi]);
         // Bits above the current slice are still zero, so OR-ing inserts it.
         assign sum_nxt[gi]   = sum_src[gi] | (word_t'(blk_sum[gi]) << (gi*BLOCK));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTAGE; k++) begin
            valid_reg[k] <= 1'b0;
            a_reg[k]     <= '0;
            b_reg[k]     <= '0;
            sum_reg[k]   <= '0;
            carry_reg[k] <= 1'b0;
         end
         ovf_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else if (!stall) begin
         valid_reg[0] <= bus.in_valid;
         for (int k = 1; k < NSTAGE; k++)
            valid_reg[k] <= valid_reg[k-1];
         for (int k = 0; k < NSTAGE; k++) begin
            a_reg[k]     <= a_src[k];
            b_reg[k]     <= b_src[k];
            sum_reg[k]   <= sum_nxt[k];
            carry_reg[k] <= carry_nxt[k];
         end
         ovf_reg  <= blk_cmsb[NSTAGE-1] ^ blk_cout[NSTAGE-1];
         zero_reg <= ~|sum_nxt[NSTAGE-1];
      end
   end

   assign bus.in_ready  = ~stall;
   assign bus.out_valid = valid_reg[NSTAGE-1];
   assign bus.out_sum   = sum_reg[NSTAGE-1];
   assign bus.out_cout  = carry_reg[NSTAGE-1];
   assign bus.out_ovf   = ovf_reg;
   assign bus.out_zero  = zero_reg;

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the uMIPS_32 datapath and for wider multi-cycle arithmetic.
- Splits a WIDTH-bit operation into WIDTH/BLOCK lookahead slices. One slice is resolved per pipeline stage, and the carry is registered between stages.
- Uses a valid/ready handshake with full-pipeline stall.
- Adds subtract mode and carry/overflow/zero flags, which the fixed 16-bit combinational adder lacks.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of BLOCK.
- BLOCK, 8, bits resolved per stage by one lookahead slice; power of two, 4..16.
- NSTAGE, WIDTH/BLOCK, derived pipeline depth (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  1  0 = add, 1 = subtract (A - B).
- in_cin  in  1  carry-in, used for add only; ignored for subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero are 0. Datapath registers are also cleared to 0. in_ready is 1 after reset.
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
  - When stalled, every stage register holds, with no bubble squeeze.
  - out_* stay stable while out_valid && !out_ready.
- Subtract: the effective B is ~in_b and the carry-in is 1. Both are formed before stage 0.
- Stage k (k = 0..NSTAGE-1):
  - Slice k, bits [k*BLOCK +: BLOCK], is computed by one cla_block using the registered carry from stage k-1. Stage 0 uses the effective carry-in.
  - Already-computed low sum slices are carried forward unchanged.
  - Not-yet-used high operand slices are skewed forward in registers.
- Latency: exactly NSTAGE cycles from the input transfer to out_valid, with no stalls. NSTAGE = 4 for the defaults.
- Throughput: 1 beat per cycle when out_ready is held high.
- Bubbles: in_valid low advances a 0 valid bit, so gaps are preserved.
- Flags are registered with the final stage:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = NOR of all out_sum bits.
- Wrap-around: add overflow wraps modulo 2^WIDTH. For example, all-ones + 1 gives sum 0, cout 1, zero 1.
- Simultaneous in/out transfer at full occupancy is legal: the pipe shifts and the new beat is accepted.
- Reset mid-operation: all in-flight beats are discarded, with no partial result emitted.
- X-safety: datapath contents of invalid stages are don't-care, but valid bits must never be X after reset.

Decomposition:
- Package cla_pkg holds:
  - op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - a function gp_merge(g_hi, p_hi, g_lo, p_lo) for lookahead group combining.
- Sub-module cla_block:
  - combinational, BLOCK-bit, with a recursive 4-bit group-lookahead tree built from gp_merge;
  - ports a, b, cin, sum, g, p, cout, and c_msb_in for overflow detection;
  - instantiated NSTAGE times in a generate loop.

Test Plan:
- Add, defaults, out_ready = 1: A = 0x0000_FFFF, B = 0x0000_0001, cin = 0 -> after 4 cycles sum = 0x0001_0000, cout = 0, ovf = 0, zero = 0.
- Wrap: A = 0xFFFF_FFFF, B = 0x0000_0000, cin = 1, add -> sum = 0x0000_0000, cout = 1, zero = 1, ovf = 0.
- Subtract signed overflow: A = 0x8000_0000, B = 0x0000_0001, op = 1 -> sum = 0x7FFF_FFFF, ovf = 1, cout = 1. Also 5 - 7 -> sum = 0xFFFF_FFFE, cout = 0.
- Back-to-back stream of 16 random beats with out_ready = 1 -> 16 results, in order, on consecutive cycles starting 4 cycles after the first beat; each matches the reference model.
- Backpressure:
  - Drive out_ready = 0 for 6 cycles with the pipe full. in_ready must drop the same cycle out_valid is 1, and out_* must hold stable.
  - On release, no beat is lost or duplicated.
- Async reset: assert rst_n low mid-stream, between clock edges. out_valid must fall immediately, and no stale result may appear after release. Rerun with WIDTH = 64 and BLOCK = 16, and with BLOCK = 4, to confirm latency equals NSTAGE.
